// File: rtl/perf_pkg.sv
// Shared types and constants for the perf counter reader.
// PERF_READER_PEAK_EN adds a third peak word to every report.
package perf_pkg;

  localparam int unsigned CW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND_BLK,
    SEND_CYC,
    SEND_PEAK
  } rd_state_t;

  localparam int unsigned W_BLK  = 0;
  localparam int unsigned W_CYC  = 1;
  localparam int unsigned W_PEAK = 2;

`ifdef PERF_READER_PEAK_EN
  localparam int unsigned N_WORDS = 3;
`else
  localparam int unsigned N_WORDS = 2;
`endif

  // Report word index carried by a send state.
  function automatic int unsigned word_of(
    input rd_state_t s
  );
    int unsigned w;
    w = W_BLK;
    unique case (s)
      SEND_CYC:  w = W_CYC;
      SEND_PEAK: w = W_PEAK;
      default:   w = W_BLK;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/perf_window_timer.sv
// Free-running window timer with early clear.
// CYCLES=0 holds the count at zero and never ticks.
module perf_window_timer #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TW =
    (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam bit EN = (CYCLES != 0);
  localparam logic [TW-1:0] LAST =
    TW'((CYCLES == 0) ? 0 : CYCLES - 1);

  logic [TW-1:0] cnt;

  assign tick = EN && (cnt == LAST);

  // Count up, restart on terminal count or clear.
  always_ff @(posedge clk) begin
    if (rst || clr || tick || !EN)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/perf_counter_reader.sv
// Samples perf counters per window and streams deltas.
// PERF_READER_PEAK_EN appends the running peak of d_blk.
module perf_counter_reader
  import perf_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = CW_DEF,
  parameter int unsigned WINDOW_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] blocks_processed,
  input  logic [COUNTER_WIDTH-1:0] cycles_elapsed,
  input  logic                     snap_req,
  output logic [COUNTER_WIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     overrun
);

  localparam int unsigned CW = COUNTER_WIDTH;

  rd_state_t state, nxt;

  logic          tick;
  logic          bnd;
  logic          take;
  logic [CW-1:0] prev_blocks;
  logic [CW-1:0] prev_cycles;
  logic [CW-1:0] d_blk;
  logic [CW-1:0] d_cyc;
  logic [CW-1:0] new_blk;
  logic [CW-1:0] new_cyc;
  logic [CW-1:0] o_data;
  logic          o_last;

  perf_window_timer #(
    .CYCLES(WINDOW_CYCLES)
  ) u_tmr (
    .clk (clk),
    .rst (rst),
    .clr (snap_req),
    .tick(tick)
  );

  assign bnd     = tick | snap_req;
  assign take    = bnd && (state == IDLE);
  assign new_blk = blocks_processed - prev_blocks;
  assign new_cyc = cycles_elapsed - prev_cycles;

`ifdef PERF_READER_PEAK_EN
  logic [CW-1:0] peak;
  logic [CW-1:0] new_peak;

  assign new_peak =
    (new_blk > peak) ? new_blk : peak;

  // Track the largest block delta since reset.
  always_ff @(posedge clk) begin
    if (rst)
      peak <= '0;
    else if (take)
      peak <= new_peak;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Report sequencer; handshakes advance a word.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bnd) nxt = SEND_BLK;
      SEND_BLK:
        if (out_ready) nxt = SEND_CYC;
      SEND_CYC:
        if (out_ready) begin
`ifdef PERF_READER_PEAK_EN
          nxt = SEND_PEAK;
`else
          nxt = IDLE;
`endif
        end
      SEND_PEAK:
        if (out_ready) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // Word to present in the next cycle.
  always_comb begin
    o_data = '0;
    o_last = 1'b0;
    unique case (nxt)
      SEND_BLK:
        o_data = take ? new_blk : d_blk;
      SEND_CYC:
        o_data = d_cyc;
`ifdef PERF_READER_PEAK_EN
      SEND_PEAK:
        o_data = peak;
`endif
      default:
        o_data = '0;
    endcase
    if (nxt != IDLE)
      o_last = (word_of(nxt) == N_WORDS - 1);
  end

  // Snapshot and delta capture on accepted boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_blocks <= '0;
      prev_cycles <= '0;
      d_blk       <= '0;
      d_cyc       <= '0;
    end else if (take) begin
      prev_blocks <= blocks_processed;
      prev_cycles <= cycles_elapsed;
      d_blk       <= new_blk;
      d_cyc       <= new_cyc;
    end
  end

  // Registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_data  <= o_data;
      out_valid <= (nxt != IDLE);
      out_last  <= o_last;
    end
  end

  // Sticky flag for boundaries dropped mid-report.
  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (bnd && (state != IDLE))
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_perf_counter_reader.sv
// Scoreboard bench for perf_counter_reader.
// Reference model works from window/delta rules directly.
module tb_perf_counter_reader;

  localparam int W  = 32;
  localparam int WC = 16;
`ifdef PERF_READER_PEAK_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] blocks_processed;
  logic [W-1:0] cycles_elapsed;
  logic         snap_req;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         overrun;

  always #5 clk = ~clk;

  perf_counter_reader #(
    .COUNTER_WIDTH(W),
    .WINDOW_CYCLES(WC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .blocks_processed(blocks_processed),
    .cycles_elapsed  (cycles_elapsed),
    .snap_req        (snap_req),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .overrun         (overrun)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         last;
  } exp_t;

  exp_t         q[$];
  int           since;
  int           rem;
  bit           m_ovr;
  logic [W-1:0] m_prev_b;
  logic [W-1:0] m_prev_c;
  logic [W-1:0] m_peak;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(
    input string        nm,
    input logic [W-1:0] act,
    input logic [W-1:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: windows, deltas, busy report.
  always @(posedge clk) begin : model
    int           old;
    bit           bnd;
    logic [W-1:0] db;
    logic [W-1:0] dc;
    if (rst) begin
      since    = 0;
      rem      = 0;
      m_ovr    = 1'b0;
      m_prev_b = '0;
      m_prev_c = '0;
      m_peak   = '0;
      q.delete();
    end else begin
      old   = rem;
      bnd   = snap_req || (since == WC - 1);
      since = bnd ? 0 : since + 1;
      if (old > 0 && out_ready)
        rem = old - 1;
      if (bnd && old == 0) begin
        db = blocks_processed - m_prev_b;
        dc = cycles_elapsed - m_prev_c;
        m_prev_b = blocks_processed;
        m_prev_c = cycles_elapsed;
        if (db > m_peak) m_peak = db;
        q.push_back('{d: db, last: 1'b0});
        q.push_back('{d: dc, last: (NW == 2)});
        if (NW == 3)
          q.push_back('{d: m_peak, last: 1'b1});
        rem = NW;
      end else if (bnd) begin
        m_ovr = 1'b1;
      end
    end
  end

  // Monitor: compare on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    chk("valid", W'(out_valid), W'(rem > 0));
    chk("overrun", W'(overrun), W'(m_ovr));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", W'(1), W'(0));
      end else begin
        e = q.pop_front();
        chk("data", out_data, e.d);
        chk("last", W'(out_last), W'(e.last));
      end
    end
  end

  logic [W-1:0] bc;
  logic [W-1:0] cc;
  int           bmode;

  // One clock; inputs change 2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
    snap_req = 1'b0;
    cc = cc + 1;
    unique case (bmode)
      1: bc = bc + 1;
      4: if (cc[1:0] == 2'd0) bc = bc + 1;
      2: bc = bc + W'($urandom_range(0, 3));
      default: ;
    endcase
    blocks_processed = bc;
    cycles_elapsed   = cc;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bc  = '0;
    cc  = '0;
    blocks_processed = bc;
    cycles_elapsed   = cc;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (n >= 200)
      chk(nm, W'(0), W'(1));
  endtask

  initial begin
    rst       = 1'b1;
    snap_req  = 1'b0;
    out_ready = 1'b1;
    bmode     = 4;
    bc        = '0;
    cc        = '0;
    blocks_processed = '0;
    cycles_elapsed   = '0;

    do_reset();
    steps(WC - 2);

    steps(6 * WC);

    wait_valid("bp_timeout");
    out_ready = 1'b0;
    steps(5);
    out_ready = 1'b1;
    steps(3 * WC);

    do_reset();
    bc = 32'hFFFF_FFF8;
    cc = 32'hFFFF_FFF0;
    bmode = 1;
    step();
    snap_req = 1'b1;
    steps(4 * WC);

    bmode = 4;
    wait_valid("ovr_timeout");
    out_ready = 1'b0;
    steps(2 * WC + 4);
    out_ready = 1'b1;
    steps(3 * WC);

    begin
      int n;
      n = 0;
      while (since != WC - 1 && n < 100) begin
        step();
        n++;
      end
      if (n >= 100)
        chk("sim_timeout", W'(0), W'(1));
      snap_req = 1'b1;
      steps(3 * WC);
    end

    bmode = 2;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 599) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      snap_req  = ($urandom_range(0, 24) == 0);
    end

    rst       = 1'b0;
    snap_req  = 1'b0;
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (rem > 0 && n < 50) begin
        step();
        n++;
      end
    end
    steps(2);
    chk("drain", W'(q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perf_counter_reader.md
Name: perf_counter_reader

Overview:
Consumer end of the performance counter interface. It samples the free-running blocks_processed and cycles_elapsed counters at window boundaries and computes per-window deltas with modulo-2^W arithmetic. It then streams a fixed-length report over a valid/ready interface to the top-level measurement and debug path. Window boundaries come from an internal window timer or from an explicit snapshot request.

Parameters:
COUNTER_WIDTH, 32, width of the sampled counters and of every report word
WINDOW_CYCLES, 1024, automatic window length in clk cycles; 0 disables the timer (request-only mode)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
blocks_processed  input  COUNTER_WIDTH  free-running block counter from performance_counter
cycles_elapsed  input  COUNTER_WIDTH  free-running cycle counter from performance_counter
snap_req  input  1  single-cycle pulse that forces a window boundary
out_data  output  COUNTER_WIDTH  report word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_last  output  1  marks the final word of a report
overrun  output  1  sticky; a boundary was dropped while a report was pending

Behaviour:
- Interface is one clock; rst is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, out_last=0, overrun=0, window timer=0, and the last-snapshot registers (prev_blocks, prev_cycles)=0. The FSM goes to IDLE.
- Window timer counts 0..WINDOW_CYCLES-1. A boundary occurs when the timer reaches WINDOW_CYCLES-1, or when snap_req=1.
- If both boundary sources fire in the same cycle, only one boundary is taken. The timer restarts at 0 on any boundary.
- FSM states: IDLE, SEND_BLK, SEND_CYC.
  - IDLE: on a boundary, capture d_blk = blocks_processed - prev_blocks and d_cyc = cycles_elapsed - prev_cycles. Both subtractions are truncated to COUNTER_WIDTH, so counter wrap yields the correct delta.
  - Also in IDLE on a boundary: load prev_* with the current inputs and go to SEND_BLK.
  - SEND_BLK: out_valid=1, out_data=d_blk, out_last=0. On handshake go to SEND_CYC.
  - SEND_CYC: out_valid=1, out_data=d_cyc, out_last=1. On handshake go to IDLE.
- Latency: out_valid rises the cycle after the boundary (registered outputs).
- Handshake rules:
  - out_data, out_valid and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
  - out_ready is ignored while out_valid=0.
- Boundary while not in IDLE: it is dropped, prev_* are NOT updated, and overrun is set to 1 until rst. The next accepted window therefore spans the dropped interval; this is intended.
- The first report after reset measures from counter value 0.
- rst mid-report aborts the report immediately; out_valid=0 in the cycle after rst is sampled.
- WINDOW_CYCLES=0: the timer is held at 0 and only snap_req creates boundaries.

Optional Feature:
Macro: PERF_READER_PEAK_EN.
- Defined:
  - A peak register holds the maximum d_blk seen since reset (reset value 0). It is updated at each accepted boundary with max(peak, new d_blk).
  - The FSM gains state SEND_PEAK after SEND_CYC. out_last moves from the SEND_CYC word to the SEND_PEAK word.
  - The report becomes 3 words: d_blk, d_cyc, peak.
- Not defined: the report is 2 words, there is no peak register, and out_last is on the d_cyc word.

Decomposition:
- Shared package perf_pkg holds:
  - the COUNTER_WIDTH default constant
  - a state enum typedef (rd_state_t: IDLE, SEND_BLK, SEND_CYC, SEND_PEAK)
  - the report word index constants
- One natural sub-module, perf_window_timer: a parameterised window counter with a clear input and a boundary pulse output.

Test Plan:
- Reset: assert rst for 2 cycles, then release -> out_valid=0 and overrun=0 for the whole idle timer period.
- WINDOW_CYCLES=16, with block_completed every 4th cycle upstream and out_ready=1 -> each report is {4, 16} with out_last on the second word. With PEAK_EN the report is {4, 16, 4}.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_data stays d_blk and out_valid stays 1. Releasing out_ready gives the words in order with no duplicates.
- Wrap-around: preload the upstream counters to 0xFFFF_FFF8, then run 16 cycles with 16 blocks and pulse snap_req -> the report is {16, 16}.
- Overrun: hold out_ready=0 across a second boundary -> overrun=1. The next report spans both windows, e.g. {8, 32} for the 2x16-cycle case above at 1 block per 4 cycles.
- Simultaneous sources: assert snap_req on the timer terminal cycle -> exactly one report, and the timer restarts at 0.
